alu_dispatch_unit: RTL and testbench
====================================

Name: alu_dispatch_unit

Overview:
- Parametrised, handshaked successor to the registered ALU function decoder.
- Accepts an op code over a valid/ready handshake and decodes its upper bits into a registered one-hot unit enable.
- Holds the enable for the target unit's latency (single- or multi-cycle), then pulses a result-valid strobe.
- Sits between the register-file/control sequencer and the arithmetic, logic, compare and shift units. Flags ops aimed at unimplemented units.

Parameters:
- FUN_W, 4, total ALU_FUN width.
- SEL_W, 2, number of ALU_FUN MSBs that select the unit. NUM_UNITS = 2**SEL_W (derived localparam).
- MC_MASK, 4'b0001, bit u = 1 means unit u is multi-cycle. Width NUM_UNITS.
- MC_LAT, 3, execute cycles for multi-cycle units. Must be ≥1; MC_LAT=1 makes them identical to single-cycle units.
- IMPL_MASK, 4'b1111, bit u = 1 means unit u exists. Width NUM_UNITS.

Ports:
- CLK  in  1  clock
- RST  in  1  reset (see interface rule below)
- CLR  in  1  synchronous abort
- OP_VALID  in  1  op request
- OP_READY  out  1  unit can accept an op
- ALU_FUN  in  FUN_W  op code; [FUN_W-1:FUN_W-SEL_W] = unit select
- EN_OH  out  NUM_UNITS  one-hot unit enable
- OP_CODE  out  FUN_W-SEL_W  latched low op bits, sub-function for the selected unit
- RES_VALID  out  1  one-cycle completion strobe
- ERR  out  1  one-cycle unimplemented-unit strobe
- BUSY  out  1  high in EXEC

Interface rule: reset RST, asynchronous, active-low; clock CLK.

Behaviour:
- **Registered outputs.** EN_OH, OP_CODE, RES_VALID and ERR are registers. OP_READY and BUSY are decoded from the state register only; there is no combinational path from any input.
- **Reset (RST=0, asynchronous).**
  - State = IDLE.
  - EN_OH = 0, OP_CODE = 0, RES_VALID = 0, ERR = 0, counter = 0.
  - OP_READY = 1, BUSY = 0.
  - Reset mid-EXEC abandons the op; no RES_VALID is ever produced for it.
- **States.**
  - IDLE: OP_READY = 1.
  - EXEC: BUSY = 1, OP_READY = 0.
  - DONE: RES_VALID = 1, OP_READY = 1.
- **Accept.** An op is accepted at edge k when OP_VALID && OP_READY && !CLR. At accept, sel = ALU_FUN upper SEL_W bits and OP_CODE <= ALU_FUN low bits.
- **Latency.** L = MC_MASK[sel] ? MC_LAT : 1.
- **Implemented unit (IMPL_MASK[sel] = 1).**
  - State -> EXEC.
  - EN_OH = (1 << sel) during cycles k+1 .. k+L, exactly L cycles.
  - Counter is loaded with L-1 and decrements each EXEC cycle; at 0 the state goes to DONE.
  - RES_VALID is high in cycle k+L+1, with EN_OH = 0 in that cycle.
- **Unimplemented unit (IMPL_MASK[sel] = 0).**
  - ERR = 1 in cycle k+1, EN_OH stays 0, state stays IDLE, OP_READY stays 1, no RES_VALID.
  - Back-to-back illegal ops produce back-to-back ERR pulses.
- **DONE cycle.**
  - An accept there goes directly to EXEC for the new op, so RES_VALID and the new EN_OH appear in adjacent cycles.
  - Otherwise the state returns to IDLE.
  - Single-cycle throughput is one op per 2 cycles.
- **OP_VALID while not ready.** Ignored. The requester must hold OP_VALID and ALU_FUN stable until accepted.
- **CLR (synchronous, highest priority after RST).**
  - From any state -> IDLE.
  - EN_OH, RES_VALID and ERR cleared next cycle; the counter is cleared.
  - No accept in the CLR cycle.
  - The aborted op gets no RES_VALID.
- **Invariants.** EN_OH is always zero or one-hot. RES_VALID and ERR are never high together. ALU_FUN changes during EXEC do not affect EN_OH or OP_CODE.
- **Counter width.** $clog2(MC_LAT+1), saturating at 0; it never wraps.

Decomposition:
- Shared package alu_pkg holds:
  - state enum {IDLE, EXEC, DONE};
  - unit-index constants ARITH=0, LOGIC=1, CMP=2, SHIFT=3;
  - default mask constants.
- One natural sub-module: alu_onehot_dec, a pure SEL_W-to-NUM_UNITS one-hot decoder gated by IMPL_MASK. The FSM, counter and output registers stay in the top.

Test Plan:
1. Reset with OP_VALID=1, ALU_FUN=4'b0101 held; release RST -> EN_OH=0 while in reset. Accept on the first edge, then EN_OH=4'b0010 and OP_CODE=2'b01 for 1 cycle, then RES_VALID=1 for 1 cycle.
2. Multi-cycle: ALU_FUN=4'b0011 (unit 0, MC_LAT=3) accepted at k -> EN_OH=4'b0001 for k+1..k+3, BUSY=1, OP_READY=0; RES_VALID at k+4.
3. Back-to-back in DONE: 4'b1000, then 4'b1110 held valid -> EN_OH 4'b0100 then RES_VALID, followed immediately by EN_OH=4'b1000. OP_CODE updates 00 -> 10.
4. IMPL_MASK=4'b0111, ALU_FUN=4'b1100 -> ERR=1 at k+1, EN_OH=0, no RES_VALID, OP_READY stays 1.
5. CLR asserted at k+2 of a 3-cycle op -> EN_OH=0 from k+3, no RES_VALID, IDLE. An OP_VALID held during CLR is accepted only on the next edge.
6. RST pulsed low mid-EXEC (async, between edges) -> all outputs 0 immediately, OP_READY=1; no RES_VALID after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU dispatch unit.
package alu_pkg;

   // Dispatcher control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Unit indices as selected by the upper ALU_FUN bits
   localparam logic [1:0] ARITH = 2'd0;
   localparam logic [1:0] LOGIC = 2'd1;
   localparam logic [1:0] CMP   = 2'd2;
   localparam logic [1:0] SHIFT = 2'd3;

   // Default unit masks: only the arithmetic unit is multi-cycle, all units present
   localparam logic [3:0] DEF_MC_MASK   = 4'b0001;
   localparam logic [3:0] DEF_IMPL_MASK = 4'b1111;

endpackage

// File: rtl/alu_onehot_dec.sv
// Unit-select to one-hot decoder; selects of absent units decode to all-zero.
module alu_onehot_dec #(
   parameter int                        SEL_W     = 2,
   localparam int                       NUM_UNITS = 2**SEL_W,
   parameter logic [NUM_UNITS-1:0]      IMPL_MASK = {NUM_UNITS{1'b1}}
) (
   input  logic [SEL_W-1:0]     sel_i,
   output logic [NUM_UNITS-1:0] oh_o
);

   // One-hot decode, suppressed for unimplemented units
   always_comb begin
      oh_o = '0;
      if (IMPL_MASK[sel_i]) begin
         oh_o = NUM_UNITS'(1) << sel_i;
      end else begin
         oh_o = '0;
      end
   end

endmodule

// File: rtl/alu_dispatch_unit.sv
// Handshaked ALU dispatcher: decodes an accepted op into a registered one-hot
// unit enable held for the unit latency, then strobes RES_VALID. Ops aimed at
// absent units produce a one-cycle ERR strobe instead.
module alu_dispatch_unit
   import alu_pkg::*;
#(
   parameter int                    FUN_W     = 4,
   parameter int                    SEL_W     = 2,
   localparam int                   NUM_UNITS = 2**SEL_W,
   parameter logic [NUM_UNITS-1:0]  MC_MASK   = DEF_MC_MASK,
   parameter int                    MC_LAT    = 3,
   parameter logic [NUM_UNITS-1:0]  IMPL_MASK = DEF_IMPL_MASK
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CLR,
   input  logic                     OP_VALID,
   output logic                     OP_READY,
   input  logic [FUN_W-1:0]         ALU_FUN,
   output logic [NUM_UNITS-1:0]     EN_OH,
   output logic [FUN_W-SEL_W-1:0]   OP_CODE,
   output logic                     RES_VALID,
   output logic                     ERR,
   output logic                     BUSY
);

   localparam int                OPC_W   = FUN_W - SEL_W;
   localparam int                CNT_W   = $clog2(MC_LAT + 1);
   // Counter preload for multi-cycle units; single-cycle units preload zero
   localparam logic [CNT_W-1:0]  MC_LOAD = CNT_W'(MC_LAT - 1);

   state_e                 state_q, state_d;
   logic [NUM_UNITS-1:0]   en_oh_q, en_oh_d;
   logic [OPC_W-1:0]       op_code_q, op_code_d;
   logic                   res_valid_q, res_valid_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [SEL_W-1:0]       sel_s;
   logic [NUM_UNITS-1:0]   dec_oh_s;
   logic                   impl_s;
   logic                   mc_s;
   logic                   accept_s;
   logic                   cnt_zero_s;
   logic                   ready_s;
   logic                   busy_s;

   assign sel_s      = ALU_FUN[FUN_W-1 -: SEL_W];
   assign impl_s     = |dec_oh_s;
   assign mc_s       = MC_MASK[sel_s];
   assign cnt_zero_s = (cnt_q == '0);
   assign accept_s   = OP_VALID && ready_s && !CLR;

   alu_onehot_dec #(
      .SEL_W     (SEL_W),
      .IMPL_MASK (IMPL_MASK)
   ) u_dec (
      .sel_i (sel_s),
      .oh_o  (dec_oh_s)
   );

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: CLR aborts to IDLE; DONE may chain straight into a new EXEC
   always_comb begin
      state_d = state_q;
      if (CLR) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept_s && impl_s) begin
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
            EXEC: begin
               if (cnt_zero_s) begin
                  state_d = DONE;
               end else begin
                  state_d = EXEC;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake/status outputs decoded purely from the state register
   always_comb begin
      ready_s = 1'b1;
      busy_s  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
         EXEC: begin
            ready_s = 1'b0;
            busy_s  = 1'b1;
         end
         DONE: begin
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
         default: begin
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Next values of the registered outputs and the latency counter
   always_comb begin
      en_oh_d     = '0;
      op_code_d   = op_code_q;
      res_valid_d = 1'b0;
      err_d       = 1'b0;
      cnt_d       = '0;
      if (CLR) begin
         en_oh_d = '0;
      end else if (accept_s) begin
         op_code_d = ALU_FUN[OPC_W-1:0];
         if (impl_s) begin
            en_oh_d = dec_oh_s;
            cnt_d   = mc_s ? MC_LOAD : '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (state_q == EXEC) begin
         if (cnt_zero_s) begin
            res_valid_d = 1'b1;
         end else begin
            en_oh_d = en_oh_q;
            cnt_d   = cnt_q - CNT_W'(1);
         end
      end else begin
         en_oh_d = '0;
      end
   end

   // Output and counter registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         en_oh_q     <= '0;
         op_code_q   <= '0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         en_oh_q     <= en_oh_d;
         op_code_q   <= op_code_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign EN_OH     = en_oh_q;
   assign OP_CODE   = op_code_q;
   assign RES_VALID = res_valid_q;
   assign ERR       = err_q;
   assign OP_READY  = ready_s;
   assign BUSY      = busy_s;

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Self-checking bench for alu_dispatch_unit: two instances (all units present,
// and SHIFT absent) share one stimulus stream and are compared every cycle
// against an op-level reference model (remaining-enable-cycles per instance).
module tb_alu_dispatch_unit;
   import alu_pkg::*;

   logic       CLK;
   logic       RST;
   logic       CLR;
   logic       OP_VALID;
   logic [3:0] ALU_FUN;

   logic       rdy_a, rv_a, err_a, bsy_a;
   logic [3:0] en_a;
   logic [1:0] code_a;
   logic       rdy_b, rv_b, err_b, bsy_b;
   logic [3:0] en_b;
   logic [1:0] code_b;

   int checks = 0;
   int errors = 0;

   // Reference model state per instance
   logic [3:0] m_en   [2];
   logic [1:0] m_code [2];
   logic       m_rv   [2];
   logic       m_err  [2];
   int         m_left [2];
   logic [3:0] m_impl [2];
   localparam logic [3:0] TB_MC_MASK = 4'b0001;
   localparam int         TB_MC_LAT  = 3;

   alu_dispatch_unit u_dut_a (
      .CLK(CLK), .RST(RST), .CLR(CLR), .OP_VALID(OP_VALID), .OP_READY(rdy_a),
      .ALU_FUN(ALU_FUN), .EN_OH(en_a), .OP_CODE(code_a), .RES_VALID(rv_a),
      .ERR(err_a), .BUSY(bsy_a)
   );

   alu_dispatch_unit #(.IMPL_MASK(4'b0111)) u_dut_b (
      .CLK(CLK), .RST(RST), .CLR(CLR), .OP_VALID(OP_VALID), .OP_READY(rdy_b),
      .ALU_FUN(ALU_FUN), .EN_OH(en_b), .OP_CODE(code_b), .RES_VALID(rv_b),
      .ERR(err_b), .BUSY(bsy_b)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(int d);
      m_en[d]   = 4'd0;
      m_code[d] = 2'd0;
      m_rv[d]   = 1'b0;
      m_err[d]  = 1'b0;
      m_left[d] = 0;
   endtask

   // Op-level behaviour at one clock edge: an instance is busy while an enable
   // is outstanding; it can take a new op whenever no enable is outstanding.
   task automatic model_edge(int d);
      int sel;
      int lat;
      if (!RST) begin
         model_reset(d);
      end else if (CLR) begin
         m_en[d] = 4'd0; m_rv[d] = 1'b0; m_err[d] = 1'b0; m_left[d] = 0;
      end else if (m_en[d] != 4'd0) begin
         m_err[d] = 1'b0;
         if (m_left[d] > 0) begin
            m_left[d] = m_left[d] - 1;
            m_rv[d]   = 1'b0;
         end else begin
            m_en[d] = 4'd0;
            m_rv[d] = 1'b1;
         end
      end else begin
         m_rv[d]  = 1'b0;
         m_err[d] = 1'b0;
         if (OP_VALID) begin
            sel       = int'(ALU_FUN[3:2]);
            m_code[d] = ALU_FUN[1:0];
            lat       = TB_MC_MASK[sel] ? TB_MC_LAT : 1;
            if (m_impl[d][sel]) begin
               m_en[d]   = 4'b0001 << sel;
               m_left[d] = lat - 1;
            end else begin
               m_err[d] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_dut(int d, string nm, logic [3:0] en, logic [1:0] code,
                            logic rv, logic err, logic rdy, logic bsy);
      chk({nm, ".en_oh"},     {4'd0, en},   {4'd0, m_en[d]});
      chk({nm, ".op_code"},   {6'd0, code}, {6'd0, m_code[d]});
      chk({nm, ".res_valid"}, {7'd0, rv},   {7'd0, m_rv[d]});
      chk({nm, ".err"},       {7'd0, err},  {7'd0, m_err[d]});
      chk({nm, ".op_ready"},  {7'd0, rdy},  {7'd0, (m_en[d] == 4'd0)});
      chk({nm, ".busy"},      {7'd0, bsy},  {7'd0, (m_en[d] != 4'd0)});
   endtask

   task automatic check_both();
      check_dut(0, "a", en_a, code_a, rv_a, err_a, rdy_a, bsy_a);
      check_dut(1, "b", en_b, code_b, rv_b, err_b, rdy_b, bsy_b);
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge
   task automatic step();
      @(posedge CLK);
      model_edge(0);
      model_edge(1);
      @(negedge CLK);
      check_both();
   endtask

   initial begin
      m_impl[0] = 4'b1111;
      m_impl[1] = 4'b0111;
      model_reset(0);
      model_reset(1);

      // 1: reset with a request already pending, accepted on the first edge
      RST = 1'b1; CLR = 1'b0; OP_VALID = 1'b1; ALU_FUN = {LOGIC, 2'b01};
      #1 RST = 1'b0;
      #2 check_both();
      @(negedge CLK);
      RST = 1'b1;
      step();
      OP_VALID = 1'b0;
      repeat (3) step();

      // 2: multi-cycle arithmetic op
      OP_VALID = 1'b1; ALU_FUN = {ARITH, 2'b11};
      step();
      OP_VALID = 1'b0;
      repeat (5) step();

      // 3: back-to-back, second op accepted in the DONE cycle
      OP_VALID = 1'b1; ALU_FUN = {CMP, 2'b00};
      step();
      ALU_FUN = {SHIFT, 2'b10};
      repeat (2) step();
      OP_VALID = 1'b0;
      repeat (3) step();

      // 4: SHIFT op (absent on instance b), issued back-to-back
      OP_VALID = 1'b1; ALU_FUN = {SHIFT, 2'b00};
      repeat (2) step();
      OP_VALID = 1'b0;
      repeat (3) step();

      // 5: CLR aborts a 3-cycle op; request held during CLR waits one edge
      OP_VALID = 1'b1; ALU_FUN = {ARITH, 2'b10};
      step();
      OP_VALID = 1'b0;
      step();
      CLR = 1'b1; OP_VALID = 1'b1; ALU_FUN = {ARITH, 2'b01};
      step();
      CLR = 1'b0;
      step();
      OP_VALID = 1'b0;
      repeat (5) step();

      // 6: asynchronous reset between edges during EXEC
      OP_VALID = 1'b1; ALU_FUN = {ARITH, 2'b11};
      step();
      OP_VALID = 1'b0;
      step();
      #1 RST = 1'b0;
      #1 model_reset(0);
      model_reset(1);
      check_both();
      step();
      RST = 1'b1;
      repeat (6) step();

      // Randomized traffic with occasional aborts
      for (int i = 0; i < 400; i++) begin
         OP_VALID = 1'($urandom_range(0, 1));
         ALU_FUN  = 4'($urandom);
         CLR      = ($urandom_range(0, 19) == 0);
         step();
      end
      CLR = 1'b0; OP_VALID = 1'b0;
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
